tristate_bus_arbiter: RTL and testbench

//  Shares one resistive-pull tri-state net between NREQ drivers. Each driver is a weak-pull tri-state buffer cell.

---
 rtl/tsarb_pkg.sv | 23 ++
 rtl/tristate_bus_arbiter_rr_pick.sv | 35 +++
 rtl/tristate_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tsarb_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
// Also holds the OE one-hot-or-zero check used by the top-level assertion.
package tsarb_pkg;

    localparam int unsigned TSARB_MAX_NREQ = 16;
    localparam int unsigned TSARB_TURN_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } tsarb_state_e;

    function automatic logic tsarb_oe_ok(input logic [TSARB_MAX_NREQ-1:0] oe);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(TSARB_MAX_NREQ); i++) begin
            cnt = cnt + {31'd0, oe[i]};
        end
        return (cnt <= 1);
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Returns the winner as one-hot and as an index, plus an any-request flag.
module tsarb_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_oh_o,
    output logic [IdW-1:0]  gnt_idx_o,
    output logic            any_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx[IdW-1:0]]) begin
                found     = 1'b1;
                gnt_idx_o = idx[IdW-1:0];
                gnt_oh_o  = NREQ'(1) << idx;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner arbiter driving the OE pins of shared weak-pull tri-state buffers.
// Define TSARB_PARK_EN to park the bus on the last owner while idle.
module tristate_bus_arbiter
    import tsarb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         REQ,
    output logic [NREQ-1:0]         GNT,
    output logic [NREQ-1:0]         OE,
    output logic [$clog2(NREQ)-1:0] GNT_ID,
    output logic                    BUS_FLOAT
);

    localparam int unsigned IdW   = $clog2(NREQ);
    localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IdW-1:0]          LastId   = IdW'(NREQ - 1);
    localparam logic [HoldW-1:0]        HoldLast = HoldW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [TSARB_TURN_W-1:0] TurnLast = TSARB_TURN_W'(TURN_CYC - 1);

    if (NREQ < 2 || NREQ > TSARB_MAX_NREQ) begin : g_bad_nreq
        $error("tristate_bus_arbiter: NREQ must be 2..16");
    end
    if (TURN_CYC < 1 || TURN_CYC > 15) begin : g_bad_turn
        $error("tristate_bus_arbiter: TURN_CYC must be 1..15");
    end

    tsarb_state_e            state_q, state_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [NREQ-1:0]         oe_q, oe_d;
    logic [IdW-1:0]          gnt_id_q, gnt_id_d;
    logic                    bus_float_q, bus_float_d;
    logic [IdW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [HoldW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [TSARB_TURN_W-1:0] turn_cnt_q, turn_cnt_d;

    logic [NREQ-1:0] pick_oh;
    logic [IdW-1:0]  pick_idx;
    logic            pick_any;
    logic            grant_now;
    logic            owner_req;
    logic            others_req;
    logic            forced;

`ifdef TSARB_PARK_EN
    logic            owned_once_q, owned_once_d;
    logic [NREQ-1:0] park_oh;
    assign park_oh = NREQ'(1) << gnt_id_q;
`endif

    tsarb_rr_pick #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_pick (
        .req_i     (REQ),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    assign owner_req  = |(REQ & gnt_q);
    assign others_req = |(REQ & ~gnt_q);
    assign forced     = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast) && others_req;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        oe_d       = oe_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;
        grant_now  = 1'b0;
`ifdef TSARB_PARK_EN
        owned_once_d = owned_once_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef TSARB_PARK_EN
                // A parked bus may only change hands through the turnaround gap.
                if (owned_once_q && |(REQ & ~park_oh)) begin
                    state_d    = TURN;
                    oe_d       = '0;
                    turn_cnt_d = '0;
                end else begin
                    grant_now = pick_any;
                end
`else
                grant_now = pick_any;
`endif
            end
            OWN: begin
                if (!owner_req || forced) begin
                    gnt_d = '0;
`ifdef TSARB_PARK_EN
                    if (!others_req) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = TURN;
                        oe_d       = '0;
                        turn_cnt_d = '0;
                    end
`else
                    state_d    = TURN;
                    oe_d       = '0;
                    turn_cnt_d = '0;
`endif
                end else if (MAX_HOLD != 0 && hold_cnt_q != HoldLast) begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            TURN: begin
                // Arbitrate on the last gap cycle so the gap is exactly TURN_CYC long.
                if (turn_cnt_q == TurnLast) begin
                    state_d   = IDLE;
                    grant_now = pick_any;
`ifdef TSARB_PARK_EN
                    if (!pick_any) begin
                        oe_d = park_oh;
                    end
`endif
                end else begin
                    turn_cnt_d = turn_cnt_q + TSARB_TURN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_now) begin
            state_d    = OWN;
            gnt_d      = pick_oh;
            oe_d       = pick_oh;
            gnt_id_d   = pick_idx;
            rr_ptr_d   = (pick_idx == LastId) ? '0 : pick_idx + IdW'(1);
            hold_cnt_d = '0;
`ifdef TSARB_PARK_EN
            owned_once_d = 1'b1;
`endif
        end
        bus_float_d = ~|oe_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            oe_q        <= '0;
            gnt_id_q    <= '0;
            bus_float_q <= 1'b1;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            turn_cnt_q  <= '0;
`ifdef TSARB_PARK_EN
            owned_once_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            oe_q        <= oe_d;
            gnt_id_q    <= gnt_id_d;
            bus_float_q <= bus_float_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
`ifdef TSARB_PARK_EN
            owned_once_q <= owned_once_d;
`endif
        end
    end

    assign GNT       = gnt_q;
    assign OE        = oe_q;
    assign GNT_ID    = gnt_id_q;
    assign BUS_FLOAT = bus_float_q;

    oe_onehot0_a: assert property (@(posedge CLK) disable iff (!RST_N)
        tsarb_oe_ok(TSARB_MAX_NREQ'(oe_q)));

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: two instances (TURN_CYC=1 and TURN_CYC=3).
// Expectations are hand-computed; park-mode checks follow TSARB_PARK_EN.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, gnt_a, oe_a;
    logic [3:0] req_b, gnt_b, oe_b;
    logic [1:0] id_a, id_b;
    logic       flt_a, flt_b;

    int tests_run;
    int tests_failed;

    tristate_bus_arbiter #(
        .NREQ     (4),
        .TURN_CYC (1),
        .MAX_HOLD (16)
    ) u_dut_a (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ       (req_a),
        .GNT       (gnt_a),
        .OE        (oe_a),
        .GNT_ID    (id_a),
        .BUS_FLOAT (flt_a)
    );

    tristate_bus_arbiter #(
        .NREQ     (4),
        .TURN_CYC (3),
        .MAX_HOLD (16)
    ) u_dut_b (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ       (req_b),
        .GNT       (gnt_b),
        .OE        (oe_b),
        .GNT_ID    (id_b),
        .BUS_FLOAT (flt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted and released between clock edges; returns 6 time units before an edge.
    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        req_a = '0;
        req_b = '0;
        #3;
        check_eq("rst_oe_a", 32'(oe_a), 32'h0);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        int owners [5];
        owners       = '{0, 1, 2, 3, 0};
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        req_a        = '0;
        req_b        = '0;
        #1 rst_n = 1'b0;
        #6;
        check_eq("reset_gnt", 32'(gnt_a), 32'h0);
        check_eq("reset_oe", 32'(oe_a), 32'h0);
        check_eq("reset_id", 32'(id_a), 32'h0);
        check_eq("reset_float", 32'(flt_a), 32'h1);
        check_eq("reset_oe_b", 32'(oe_b), 32'h0);
        check_eq("reset_float_b", 32'(flt_b), 32'h1);
        #5 rst_n = 1'b1;

        // 1: single requester, latency 1, release
        req_a = 4'b0001;
        tick();
        check_eq("t1_gnt", 32'(gnt_a), 32'h1);
        check_eq("t1_oe", 32'(oe_a), 32'h1);
        check_eq("t1_float", 32'(flt_a), 32'h0);
        check_eq("t1_id", 32'(id_a), 32'h0);
        req_a = 4'b0000;
        tick();
        check_eq("t1_rel_gnt", 32'(gnt_a), 32'h0);
`ifdef TSARB_PARK_EN
        check_eq("t1_rel_oe_park", 32'(oe_a), 32'h1);
        check_eq("t1_rel_float_park", 32'(flt_a), 32'h0);
`else
        check_eq("t1_rel_oe", 32'(oe_a), 32'h0);
        check_eq("t1_rel_float", 32'(flt_a), 32'h1);
        tick();
        check_eq("t1_idle_oe", 32'(oe_a), 32'h0);
`endif

        // 2: all request, forced release every 16 cycles with a 1-cycle gap
        do_reset();
        req_a = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 16; k++) begin
                tick();
                check_eq($sformatf("t2_oe_o%0d_c%0d", j, k), 32'(oe_a), 32'(1 << owners[j]));
                check_eq($sformatf("t2_gnt_o%0d_c%0d", j, k), 32'(gnt_a), 32'(1 << owners[j]));
                if (k == 0) begin
                    check_eq($sformatf("t2_id_o%0d", j), 32'(id_a), 32'(owners[j]));
                end
            end
            if (j < 4) begin
                tick();
                check_eq($sformatf("t2_gap_oe_%0d", j), 32'(oe_a), 32'h0);
                check_eq($sformatf("t2_gap_float_%0d", j), 32'(flt_a), 32'h1);
            end
        end

        // 3: lone requester is never forced off
        do_reset();
        req_a = 4'b0100;
        tick();
        for (int k = 0; k < 40; k++) begin
            check_eq($sformatf("t3_oe_c%0d", k), 32'(oe_a), 32'h4);
            tick();
        end
        check_eq("t3_id", 32'(id_a), 32'h2);

        // 4: TURN_CYC=3 gap between owner 1 and owner 3
        do_reset();
        req_b = 4'b0010;
        tick();
        check_eq("t4_own1", 32'(oe_b), 32'h2);
        req_b = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("t4_hold_c%0d", k), 32'(oe_b), 32'h2);
        end
        req_b = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("t4_gap_c%0d", k), 32'(oe_b), 32'h0);
            check_eq($sformatf("t4_pop_c%0d", k), 32'($countones(oe_b) <= 1), 32'h1);
        end
        tick();
        check_eq("t4_own3", 32'(oe_b), 32'h8);
        check_eq("t4_id3", 32'(id_b), 32'h3);
        check_eq("t4_pop_end", 32'($countones(oe_b) <= 1), 32'h1);

        // 5: asynchronous reset mid-tenure
        do_reset();
        req_a = 4'b0001;
        tick();
        check_eq("t5_own0", 32'(oe_a), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_oe", 32'(oe_a), 32'h0);
        check_eq("t5_async_gnt", 32'(gnt_a), 32'h0);
        check_eq("t5_async_float", 32'(flt_a), 32'h1);
        req_a = 4'b0010;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        tick();
        check_eq("t5_regrant_oe", 32'(oe_a), 32'h2);
        check_eq("t5_regrant_id", 32'(id_a), 32'h1);

        // 6: parking behaviour (or plain float when parking is off)
        do_reset();
        req_a = 4'b0001;
        tick();
        check_eq("t6_own0", 32'(oe_a), 32'h1);
        req_a = 4'b0000;
        tick();
        tick();
`ifdef TSARB_PARK_EN
        check_eq("t6_park_oe", 32'(oe_a), 32'h1);
        check_eq("t6_park_gnt", 32'(gnt_a), 32'h0);
        check_eq("t6_park_float", 32'(flt_a), 32'h0);
        req_a = 4'b0001;
        tick();
        check_eq("t6_reown_gnt", 32'(gnt_a), 32'h1);
        check_eq("t6_reown_oe", 32'(oe_a), 32'h1);
        req_a = 4'b0000;
        tick();
        check_eq("t6_repark_gnt", 32'(gnt_a), 32'h0);
        req_a = 4'b0100;
        tick();
        check_eq("t6_unpark_gap", 32'(oe_a), 32'h0);
        tick();
        check_eq("t6_own2_oe", 32'(oe_a), 32'h4);
        check_eq("t6_own2_gnt", 32'(gnt_a), 32'h4);
`else
        check_eq("t6_float_oe", 32'(oe_a), 32'h0);
        check_eq("t6_float_gnt", 32'(gnt_a), 32'h0);
        check_eq("t6_float_bus", 32'(flt_a), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
